// File: rtl/attn_job_ctrl.sv
// Job sequencer for the 8x8 PE attention array: accepts one key/query/value job,
// runs the array and returns its result. Optional RUN timeout: `define ATTN_TIMEOUT_EN.
module attn_job_ctrl #(
  parameter int DATA_W     = 512,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_key,
  input  logic [DATA_W-1:0] in_query,
  input  logic [DATA_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_err,
  output logic              busy,
  output logic [15:0]       job_cnt,
  output logic              pe_en,
  output logic              pe_rst_n,
  output logic [DATA_W-1:0] pe_key,
  output logic [DATA_W-1:0] pe_query,
  output logic [DATA_W-1:0] pe_value,
  input  logic [DATA_W-1:0] pe_final_res,
  input  logic              pe_all_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] clr_cnt;
  logic       run_armed;
  logic       accept;
  logic       done_hit;
  logic       tmo_hit;
  logic       consume;

  // Out-of-range parameters leave a named marker block in the elaborated hierarchy.
  if (CLR_CYCLES < 1 || CLR_CYCLES > 15 || TIMEOUT < 1) begin : g_param_out_of_range
  end

  assign accept   = (state == IDLE) && in_valid;
  // run_armed is low in the first RUN cycle, masking a done level left over from the previous job.
  assign done_hit = (state == RUN) && run_armed && pe_all_done;
  assign consume  = (state == DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == CLR_LAST) state_nxt = RUN;
      RUN:     if (done_hit || tmo_hit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    pe_en     = (state == CLEAR) || (state == RUN);
    pe_rst_n  = (state == RUN);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_key    <= '0;
      pe_query  <= '0;
      pe_value  <= '0;
      out_res   <= '0;
      job_cnt   <= 16'd0;
      clr_cnt   <= 4'd0;
      run_armed <= 1'b0;
    end else begin
      if (accept) begin
        pe_key   <= in_key;
        pe_query <= in_query;
        pe_value <= in_value;
      end
      clr_cnt   <= (state == CLEAR) ? clr_cnt + 4'd1 : 4'd0;
      run_armed <= (state == RUN);
      if (done_hit) begin
        out_res <= pe_final_res;
      end else if (tmo_hit) begin
        out_res <= '0;
      end
      if (consume && !out_err) begin
        job_cnt <= job_cnt + 16'd1;
      end
    end
  end

`ifdef ATTN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] run_cnt;

  // A real result in the expiring cycle still wins over the abort.
  assign tmo_hit = (state == RUN) && (run_cnt == TMO_LAST) && !done_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      out_err <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + TMO_W'(1) : '0;
      if (done_hit) begin
        out_err <= 1'b0;
      end else if (tmo_hit) begin
        out_err <= 1'b1;
      end else if (consume) begin
        out_err <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_attn_job_ctrl.sv
// Self-checking bench for attn_job_ctrl: directed scenarios plus randomized jobs
// checked against a latency/result model of the job sequence.
module tb_attn_job_ctrl;

  localparam int DATA_W = 512;
  localparam int CLR    = 2;
  localparam int TMO    = 64;
  localparam int LANES  = DATA_W / 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_key = '0;
  logic [DATA_W-1:0] in_query = '0;
  logic [DATA_W-1:0] in_value = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_res;
  logic              out_err;
  logic              busy;
  logic [15:0]       job_cnt;
  logic              pe_en;
  logic              pe_rst_n;
  logic [DATA_W-1:0] pe_key;
  logic [DATA_W-1:0] pe_query;
  logic [DATA_W-1:0] pe_value;
  logic [DATA_W-1:0] pe_final_res;
  logic              pe_all_done;

  // Array model: done rises through a register once N RUN cycles have elapsed,
  // so it is seen in RUN cycle N+2; tasks may take over done/result directly.
  logic              man_mode = 1'b0;
  logic              man_done = 1'b0;
  logic [DATA_W-1:0] man_res = '0;
  logic [DATA_W-1:0] model_res = '0;
  int unsigned       done_after = 32'hFFFF_FFFF;
  int unsigned       run_edges = 0;
  logic              model_done = 1'b0;

  int          tests_run = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  attn_job_ctrl #(.DATA_W(DATA_W), .CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_query(in_query), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_err(out_err),
    .busy(busy), .job_cnt(job_cnt),
    .pe_en(pe_en), .pe_rst_n(pe_rst_n),
    .pe_key(pe_key), .pe_query(pe_query), .pe_value(pe_value),
    .pe_final_res(pe_final_res), .pe_all_done(pe_all_done)
  );

  always @(posedge clk) begin
    if (pe_en && pe_rst_n) begin
      run_edges  <= run_edges + 1;
      model_done <= (run_edges >= done_after);
    end else begin
      run_edges  <= 0;
      model_done <= 1'b0;
    end
  end

  assign pe_all_done  = man_mode ? man_done : model_done;
  assign pe_final_res = man_mode ? man_res : model_res;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] rand_bus();
    logic [DATA_W-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*16 +: 16] = 16'($urandom);
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] lane_bus(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  // Presents a job and returns at the first falling edge after the handshake edge.
  task automatic send_job(input logic [DATA_W-1:0] k, q, v, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1; in_key = k; in_query = q; in_value = v;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int start, input int limit, output int c);
    c = start;
    while (!out_valid && c < limit) begin tick(); c++; end
  endtask

  task automatic consume();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    tests_run += 11;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_err got %b want 0", out_err); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (job_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_job_cnt got %0d want 0", job_cnt); end
    if (pe_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_pe_en got %b want 0", pe_en); end
    if (pe_rst_n !== 1'b0) begin fails++; $display("[TB] FAIL reset_pe_rst_n got %b want 0", pe_rst_n); end
    if (out_res !== '0) begin fails++; $display("[TB] FAIL reset_out_res got %h want 0", out_res); end
    if (pe_key !== '0) begin fails++; $display("[TB] FAIL reset_pe_key got %h want 0", pe_key); end
    if (pe_query !== '0) begin fails++; $display("[TB] FAIL reset_pe_query got %h want 0", pe_query); end
    if (pe_value !== '0) begin fails++; $display("[TB] FAIL reset_pe_value got %h want 0", pe_value); end
    rst = 1'b0; tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    man_mode = 1'b0; done_after = 20; model_res = rand_bus();
    send_job(rand_bus(), rand_bus(), rand_bus(), ok);
    for (int i = 0; i < 6; i++) tick();
    tests_run += 2;
    if (ok !== 1'b1) begin fails++; $display("[TB] FAIL midrst_accept got %b want 1", ok); end
    if (pe_rst_n !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_run got %b want 1", pe_rst_n); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run += 7;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    if (pe_rst_n !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pe_rst_n got %b want 0", pe_rst_n); end
    if (pe_en !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pe_en got %b want 0", pe_en); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_out_valid got %b want 0", out_valid); end
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL midrst_job_cnt got %0d want %0d", job_cnt, exp_cnt); end
    if (pe_key !== '0) begin fails++; $display("[TB] FAIL midrst_pe_key got %h want 0", pe_key); end
    for (int i = 0; i < 30; i++) tick();
    tests_run += 2;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_no_result got %b want 0", out_valid); end
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL midrst_job_cnt_later got %0d want %0d", job_cnt, exp_cnt); end
  endtask

  task automatic test_single_job();
    bit ok;
    int c;
    logic [DATA_W-1:0] exp_res;
    for (int i = 0; i < LANES; i++) exp_res[i*16 +: 16] = 16'(i);
    man_mode = 1'b0; done_after = 20; model_res = exp_res;
    send_job(lane_bus(16'h0001), lane_bus(16'h0002), lane_bus(16'h0003), ok);
    tests_run += 5;
    if (ok !== 1'b1) begin fails++; $display("[TB] FAIL single_accept got %b want 1", ok); end
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single_busy got %b want 1", busy); end
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_in_ready_drop got %b want 0", in_ready); end
    if ({pe_en, pe_rst_n} !== 2'b10) begin fails++; $display("[TB] FAIL single_clear1 got %b want 10", {pe_en, pe_rst_n}); end
    tick();
    if ({pe_en, pe_rst_n} !== 2'b10) begin fails++; $display("[TB] FAIL single_clear2 got %b want 10", {pe_en, pe_rst_n}); end
    tick();
    tests_run += 1;
    if ({pe_en, pe_rst_n} !== 2'b11) begin fails++; $display("[TB] FAIL single_run1 got %b want 11", {pe_en, pe_rst_n}); end
    wait_valid(2, 80, c);
    tests_run += 7;
    if (c !== CLR + 22) begin fails++; $display("[TB] FAIL single_latency got %0d want %0d", c, CLR + 22); end
    if (out_res !== exp_res) begin fails++; $display("[TB] FAIL single_out_res got %h want %h", out_res, exp_res); end
    if (pe_key !== lane_bus(16'h0001)) begin fails++; $display("[TB] FAIL single_pe_key got %h", pe_key); end
    if (pe_query !== lane_bus(16'h0002)) begin fails++; $display("[TB] FAIL single_pe_query got %h", pe_query); end
    if (pe_value !== lane_bus(16'h0003)) begin fails++; $display("[TB] FAIL single_pe_value got %h", pe_value); end
    if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL single_out_err got %b want 0", out_err); end
    if ({pe_en, pe_rst_n} !== 2'b00) begin fails++; $display("[TB] FAIL single_done_pe got %b want 00", {pe_en, pe_rst_n}); end
    consume();
    exp_cnt = exp_cnt + 16'd1;
    tests_run += 3;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_consumed got %b want 0", out_valid); end
    if (job_cnt !== 16'd1) begin fails++; $display("[TB] FAIL single_job_cnt got %0d want 1", job_cnt); end
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL single_in_ready_back got %b want 1", in_ready); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int c;
    logic [DATA_W-1:0] r1;
    r1 = rand_bus();
    man_mode = 1'b1; man_done = 1'b0; man_res = r1;
    send_job(rand_bus(), rand_bus(), rand_bus(), ok);
    for (int i = 0; i < 8; i++) tick();
    man_done = 1'b1;
    wait_valid(8, 20, c);
    tests_run += 2;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_out_valid got %b want 1", out_valid); end
    if (out_res !== r1) begin fails++; $display("[TB] FAIL bp_capture got %h want %h", out_res, r1); end
    for (int i = 0; i < 10; i++) begin
      man_res = rand_bus(); man_done = 1'($urandom_range(0, 1));
      tick();
      tests_run += 4;
      if (out_res !== r1) begin fails++; $display("[TB] FAIL bp_hold_res got %h want %h", out_res, r1); end
      if (busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_busy got %b want 1", busy); end
      if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); end
      if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_hold_valid got %b want 1", out_valid); end
    end
    consume();
    exp_cnt = exp_cnt + 16'd1;
    tests_run += 3;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_in_ready_back got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_consumed got %b want 0", out_valid); end
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL bp_job_cnt got %0d want %0d", job_cnt, exp_cnt); end
    man_mode = 1'b0; man_done = 1'b0;
  endtask

  task automatic test_stale_done();
    bit ok;
    int c;
    man_mode = 1'b1; man_done = 1'b1; man_res = lane_bus(16'hA5FF);
    send_job(rand_bus(), rand_bus(), rand_bus(), ok);
    c = 0;
    while (!out_valid && c < 40) begin
      man_res = lane_bus(16'hA500 + 16'(c));
      tick(); c++;
    end
    tests_run += 2;
    if (c !== CLR + 2) begin fails++; $display("[TB] FAIL stale_latency got %0d want %0d", c, CLR + 2); end
    if (out_res !== lane_bus(16'hA500 + 16'(CLR + 1))) begin fails++; $display("[TB] FAIL stale_capture got %h", out_res); end
    man_done = 1'b0;
    consume();
    exp_cnt = exp_cnt + 16'd1;
    tests_run += 1;
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL stale_job_cnt got %0d want %0d", job_cnt, exp_cnt); end
    man_mode = 1'b0;
  endtask

  task automatic test_busy_request();
    bit ok;
    int c;
    logic [DATA_W-1:0] k1, q1, v1;
    k1 = rand_bus(); q1 = rand_bus(); v1 = rand_bus();
    man_mode = 1'b0; done_after = 10; model_res = rand_bus();
    send_job(k1, q1, v1, ok);
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b1; in_key = lane_bus(16'hFFFF); in_query = lane_bus(16'hFFFF); in_value = lane_bus(16'hFFFF);
    wait_valid(3, 60, c);
    tests_run += 5;
    if (c !== CLR + 12) begin fails++; $display("[TB] FAIL busy_latency got %0d want %0d", c, CLR + 12); end
    if (pe_key !== k1) begin fails++; $display("[TB] FAIL busy_pe_key got %h want %h", pe_key, k1); end
    if (pe_query !== q1) begin fails++; $display("[TB] FAIL busy_pe_query got %h want %h", pe_query, q1); end
    if (pe_value !== v1) begin fails++; $display("[TB] FAIL busy_pe_value got %h want %h", pe_value, v1); end
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL busy_in_ready got %b want 0", in_ready); end
    consume();
    exp_cnt = exp_cnt + 16'd1;
    tests_run += 3;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL busy_idle_ready got %b want 1", in_ready); end
    if (pe_key !== k1) begin fails++; $display("[TB] FAIL busy_no_early_accept got %h want %h", pe_key, k1); end
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL busy_job_cnt got %0d want %0d", job_cnt, exp_cnt); end
    tick();
    in_valid = 1'b0;
    tests_run += 2;
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL busy_second_accept got %b want 1", busy); end
    if (pe_key !== lane_bus(16'hFFFF)) begin fails++; $display("[TB] FAIL busy_second_key got %h", pe_key); end
    wait_valid(0, 60, c);
    tests_run += 2;
    if (c !== CLR + 12) begin fails++; $display("[TB] FAIL busy_second_latency got %0d want %0d", c, CLR + 12); end
    if (out_res !== model_res) begin fails++; $display("[TB] FAIL busy_second_res got %h want %h", out_res, model_res); end
    consume();
    exp_cnt = exp_cnt + 16'd1;
    tests_run += 1;
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL busy_second_cnt got %0d want %0d", job_cnt, exp_cnt); end
  endtask

  task automatic test_random_jobs();
    bit ok;
    int c, n, d;
    bit early;
    logic [DATA_W-1:0] k, q, v, r;
    man_mode = 1'b0;
    for (int j = 0; j < 25; j++) begin
      k = rand_bus(); q = rand_bus(); v = rand_bus(); r = rand_bus();
      n = $urandom_range(0, 12);
      early = 1'($urandom_range(0, 1));
      done_after = n; model_res = r;
      for (int g = 0; g < $urandom_range(0, 3); g++) tick();
      out_ready = early;
      send_job(k, q, v, ok);
      wait_valid(0, 60, c);
      tests_run += 5;
      if (c !== CLR + n + 2) begin fails++; $display("[TB] FAIL rand_latency job %0d got %0d want %0d", j, c, CLR + n + 2); end
      if (out_res !== r) begin fails++; $display("[TB] FAIL rand_res job %0d got %h want %h", j, out_res, r); end
      if (pe_key !== k) begin fails++; $display("[TB] FAIL rand_pe_key job %0d got %h want %h", j, pe_key, k); end
      if (pe_query !== q) begin fails++; $display("[TB] FAIL rand_pe_query job %0d got %h want %h", j, pe_query, q); end
      if (pe_value !== v) begin fails++; $display("[TB] FAIL rand_pe_value job %0d got %h want %h", j, pe_value, v); end
      if (early) begin
        tick();
        out_ready = 1'b0;
      end else begin
        d = $urandom_range(0, 4);
        for (int w = 0; w < d; w++) begin
          tick();
          tests_run += 1;
          if (out_valid !== 1'b1 || out_res !== r) begin fails++; $display("[TB] FAIL rand_hold job %0d got valid %b res %h want 1 %h", j, out_valid, out_res, r); end
        end
        consume();
      end
      exp_cnt = exp_cnt + 16'd1;
      tests_run += 2;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rand_consumed job %0d got %b want 0", j, out_valid); end
      if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL rand_job_cnt job %0d got %0d want %0d", j, job_cnt, exp_cnt); end
    end
  endtask

`ifdef ATTN_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c;
    logic [DATA_W-1:0] r;
    man_mode = 1'b0; done_after = 32'hFFFF_FFFF; model_res = rand_bus();
    send_job(rand_bus(), rand_bus(), rand_bus(), ok);
    wait_valid(0, 200, c);
    tests_run += 3;
    if (c !== CLR + TMO) begin fails++; $display("[TB] FAIL tmo_latency got %0d want %0d", c, CLR + TMO); end
    if (out_err !== 1'b1) begin fails++; $display("[TB] FAIL tmo_err got %b want 1", out_err); end
    if (out_res !== '0) begin fails++; $display("[TB] FAIL tmo_res got %h want 0", out_res); end
    consume();
    tests_run += 2;
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL tmo_job_cnt got %0d want %0d", job_cnt, exp_cnt); end
    if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL tmo_err_clear got %b want 0", out_err); end
    r = rand_bus();
    man_mode = 1'b1; man_done = 1'b0; man_res = r;
    send_job(rand_bus(), rand_bus(), rand_bus(), ok);
    for (int i = 0; i < CLR + TMO - 1; i++) tick();
    tests_run += 1;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL tmo_race_early got %b want 0", out_valid); end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tests_run += 3;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL tmo_race_valid got %b want 1", out_valid); end
    if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL tmo_race_err got %b want 0", out_err); end
    if (out_res !== r) begin fails++; $display("[TB] FAIL tmo_race_res got %h want %h", out_res, r); end
    consume();
    exp_cnt = exp_cnt + 16'd1;
    tests_run += 1;
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL tmo_race_cnt got %0d want %0d", job_cnt, exp_cnt); end
    man_mode = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    man_mode = 1'b0; done_after = 32'hFFFF_FFFF;
    send_job(rand_bus(), rand_bus(), rand_bus(), ok);
    for (int i = 0; i < 150; i++) tick();
    tests_run += 4;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL notmo_valid got %b want 0", out_valid); end
    if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL notmo_err got %b want 0", out_err); end
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL notmo_busy got %b want 1", busy); end
    if (pe_rst_n !== 1'b1) begin fails++; $display("[TB] FAIL notmo_running got %b want 1", pe_rst_n); end
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cnt = 16'd0;
    tests_run += 2;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL notmo_recover got %b want 0", busy); end
    if (job_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL notmo_cnt_reset got %0d want 0", job_cnt); end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_mid_reset();
    test_single_job();
    test_back_pressure();
    test_stale_done();
    test_busy_request();
    test_random_jobs();
`ifdef ATTN_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
